// File: rtl/gcn_batch_sched.sv
// -----------------------------------------------------------------------------
// gcn_batch_sched
//
// Multi-batch process scheduler for the GCN backend. One process command
// carries N batches. NUM_BUF global-buffer slots rotate through three phases:
// load (DRAM->GB), compute (MAC array) and store (GB->DRAM). Phases of
// different batches overlap. Each unit gets in-order, one-at-a-time requests
// that carry a slot index and, for load/store, the DRAM batch address.
//
// Ports
//   clock, reset_n          single clock, asynchronous active-low reset
//   process_valid           start request (sampled only while idle)
//   process_nbatch          batch count (clamped to MAX_BATCHES at start)
//   process_raddr/_waddr    read / write DRAM base addresses
//   process_active          high while the command runs
//   process_done            one-cycle completion pulse
//   load_req/buf/addr       load unit request, slot and DRAM read address
//   comp_req/buf            compute unit request and slot
//   store_req/buf/addr      store unit request, slot and DRAM write address
//   load/comp/store_done    one-cycle completion pulses from the units
//   protocol_err            sticky flag: done pulse with nothing outstanding
// -----------------------------------------------------------------------------
module gcn_batch_sched #(
   parameter int NUM_BUF     = 2,
   parameter int MAX_BATCHES = 16,
   parameter int ADDR_WIDTH  = 32,
   parameter int ADDR_STRIDE = 512
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             process_valid,
   input  logic [$clog2(MAX_BATCHES+1)-1:0] process_nbatch,
   input  logic [ADDR_WIDTH-1:0]            process_raddr,
   input  logic [ADDR_WIDTH-1:0]            process_waddr,
   output logic                             process_active,
   output logic                             process_done,
   output logic                             load_req,
   output logic [$clog2(NUM_BUF)-1:0]       load_buf,
   output logic [ADDR_WIDTH-1:0]            load_addr,
   input  logic                             load_done,
   output logic                             comp_req,
   output logic [$clog2(NUM_BUF)-1:0]       comp_buf,
   input  logic                             comp_done,
   output logic                             store_req,
   output logic [$clog2(NUM_BUF)-1:0]       store_buf,
   output logic [ADDR_WIDTH-1:0]            store_addr,
   input  logic                             store_done,
   output logic                             protocol_err
);

   localparam int CW = $clog2(MAX_BATCHES + 1);
   localparam int BW = $clog2(NUM_BUF);

   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);
   localparam logic [CW-1:0]         NB_MAX = CW'(MAX_BATCHES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } top_state_e;

   typedef enum logic [2:0] {
      SLOT_FREE      = 3'd0,
      SLOT_LOADING   = 3'd1,
      SLOT_LOADED    = 3'd2,
      SLOT_COMPUTING = 3'd3,
      SLOT_COMPUTED  = 3'd4,
      SLOT_STORING   = 3'd5
   } slot_state_e;

   // Slot pointers wrap at NUM_BUF, which need not be a power of two.
   function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
      return (p == BW'(NUM_BUF - 1)) ? '0 : p + BW'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   top_state_e              state_q, state_d;
   logic [CW-1:0]           nbatch_q, nbatch_d;
   logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
   logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;

   logic [BW-1:0]           load_ptr_q, load_ptr_d;
   logic [BW-1:0]           comp_ptr_q, comp_ptr_d;
   logic [BW-1:0]           store_ptr_q, store_ptr_d;

   logic [CW-1:0]           loads_issued_q, loads_issued_d;
   logic [CW-1:0]           stores_issued_q, stores_issued_d;
   logic [CW-1:0]           stores_cmpl_q, stores_cmpl_d;

   logic                    load_busy_q, load_busy_d;
   logic                    comp_busy_q, comp_busy_d;
   logic                    store_busy_q, store_busy_d;

   slot_state_e             slot_q [NUM_BUF];
   slot_state_e             slot_d [NUM_BUF];

   logic                    load_req_q, load_req_d;
   logic [BW-1:0]           load_buf_q, load_buf_d;
   logic [ADDR_WIDTH-1:0]   load_addr_q, load_addr_d;
   logic                    comp_req_q, comp_req_d;
   logic [BW-1:0]           comp_buf_q, comp_buf_d;
   logic                    store_req_q, store_req_d;
   logic [BW-1:0]           store_buf_q, store_buf_d;
   logic [ADDR_WIDTH-1:0]   store_addr_q, store_addr_d;

   logic                    perr_q, perr_d;

   // A done pulse is honoured only when its unit has a request outstanding.
   logic load_ok, comp_ok, store_ok, spurious;
   logic [CW-1:0] nbatch_clamp;

   assign load_ok  = load_done  & load_busy_q;
   assign comp_ok  = comp_done  & comp_busy_q;
   assign store_ok = store_done & store_busy_q;
   assign spurious = (load_done  & ~load_busy_q) |
                     (comp_done  & ~comp_busy_q) |
                     (store_done & ~store_busy_q);

   assign nbatch_clamp = (process_nbatch > NB_MAX) ? NB_MAX : process_nbatch;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets its hold value first, so no branch can leave
      // one unassigned and infer a latch.
      state_d         = state_q;
      nbatch_d        = nbatch_q;
      raddr_d         = raddr_q;
      waddr_d         = waddr_q;
      load_ptr_d      = load_ptr_q;
      comp_ptr_d      = comp_ptr_q;
      store_ptr_d     = store_ptr_q;
      loads_issued_d  = loads_issued_q;
      stores_issued_d = stores_issued_q;
      stores_cmpl_d   = stores_cmpl_q;
      load_busy_d     = load_busy_q;
      comp_busy_d     = comp_busy_q;
      store_busy_d    = store_busy_q;
      for (int i = 0; i < NUM_BUF; i++) begin
         slot_d[i] = slot_q[i];
      end
      load_req_d      = 1'b0;
      comp_req_d      = 1'b0;
      store_req_d     = 1'b0;
      load_buf_d      = load_buf_q;
      load_addr_d     = load_addr_q;
      comp_buf_d      = comp_buf_q;
      store_buf_d     = store_buf_q;
      store_addr_d    = store_addr_q;
      perr_d          = perr_q;

      if (spurious) begin
         perr_d = 1'b1;
      end

      // Completions. The three units always finish on distinct slots.
      if (load_ok) begin
         slot_d[load_ptr_q] = SLOT_LOADED;
         load_ptr_d         = ptr_inc(load_ptr_q);
         load_busy_d        = 1'b0;
      end
      if (comp_ok) begin
         slot_d[comp_ptr_q] = SLOT_COMPUTED;
         comp_ptr_d         = ptr_inc(comp_ptr_q);
         comp_busy_d        = 1'b0;
      end
      if (store_ok) begin
         slot_d[store_ptr_q] = SLOT_FREE;
         store_ptr_d         = ptr_inc(store_ptr_q);
         store_busy_d        = 1'b0;
         stores_cmpl_d       = stores_cmpl_q + CW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (process_valid) begin
               state_d         = ST_RUN;
               nbatch_d        = nbatch_clamp;
               raddr_d         = process_raddr;
               waddr_d         = process_waddr;
               // All slots are FREE between commands; restarting the pointers
               // makes every command begin on slot 0.
               load_ptr_d      = '0;
               comp_ptr_d      = '0;
               store_ptr_d     = '0;
               loads_issued_d  = '0;
               stores_issued_d = '0;
               stores_cmpl_d   = '0;
               // The first load is issued from the start cycle itself so its
               // request appears together with process_active.
               if (nbatch_clamp != '0) begin
                  load_req_d     = 1'b1;
                  load_buf_d     = '0;
                  load_addr_d    = process_raddr;
                  slot_d[0]      = SLOT_LOADING;
                  load_busy_d    = 1'b1;
                  loads_issued_d = CW'(1);
               end
            end
         end

         ST_RUN: begin
            if (stores_cmpl_q == nbatch_q) begin
               state_d = ST_DONE;
            end else begin
               // Own-unit done is bypassed (busy/pointer) so a unit can
               // re-issue the cycle after its done; slot states come from the
               // registers, so another unit's done is seen one cycle later.
               if ((!load_busy_q || load_ok) &&
                   (slot_q[load_ptr_d] == SLOT_FREE) &&
                   (loads_issued_q < nbatch_q)) begin
                  load_req_d          = 1'b1;
                  load_buf_d          = load_ptr_d;
                  load_addr_d         = raddr_q + ADDR_WIDTH'(loads_issued_q) * STRIDE;
                  slot_d[load_ptr_d]  = SLOT_LOADING;
                  load_busy_d         = 1'b1;
                  loads_issued_d      = loads_issued_q + CW'(1);
               end
               if ((!comp_busy_q || comp_ok) &&
                   (slot_q[comp_ptr_d] == SLOT_LOADED)) begin
                  comp_req_d          = 1'b1;
                  comp_buf_d          = comp_ptr_d;
                  slot_d[comp_ptr_d]  = SLOT_COMPUTING;
                  comp_busy_d         = 1'b1;
               end
               if ((!store_busy_q || store_ok) &&
                   (slot_q[store_ptr_d] == SLOT_COMPUTED)) begin
                  store_req_d         = 1'b1;
                  store_buf_d         = store_ptr_d;
                  store_addr_d        = waddr_q + ADDR_WIDTH'(stores_issued_q) * STRIDE;
                  slot_d[store_ptr_d] = SLOT_STORING;
                  store_busy_d        = 1'b1;
                  stores_issued_d     = stores_issued_q + CW'(1);
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         nbatch_q        <= '0;
         raddr_q         <= '0;
         waddr_q         <= '0;
         load_ptr_q      <= '0;
         comp_ptr_q      <= '0;
         store_ptr_q     <= '0;
         loads_issued_q  <= '0;
         stores_issued_q <= '0;
         stores_cmpl_q   <= '0;
         load_busy_q     <= 1'b0;
         comp_busy_q     <= 1'b0;
         store_busy_q    <= 1'b0;
         // NOTE: the slot-state array is control state, not data storage, so
         // it is reset with everything else; an abort must leave all slots FREE.
         for (int i = 0; i < NUM_BUF; i++) begin
            slot_q[i] <= SLOT_FREE;
         end
         load_req_q      <= 1'b0;
         load_buf_q      <= '0;
         load_addr_q     <= '0;
         comp_req_q      <= 1'b0;
         comp_buf_q      <= '0;
         store_req_q     <= 1'b0;
         store_buf_q     <= '0;
         store_addr_q    <= '0;
         perr_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         nbatch_q        <= nbatch_d;
         raddr_q         <= raddr_d;
         waddr_q         <= waddr_d;
         load_ptr_q      <= load_ptr_d;
         comp_ptr_q      <= comp_ptr_d;
         store_ptr_q     <= store_ptr_d;
         loads_issued_q  <= loads_issued_d;
         stores_issued_q <= stores_issued_d;
         stores_cmpl_q   <= stores_cmpl_d;
         load_busy_q     <= load_busy_d;
         comp_busy_q     <= comp_busy_d;
         store_busy_q    <= store_busy_d;
         for (int i = 0; i < NUM_BUF; i++) begin
            slot_q[i] <= slot_d[i];
         end
         load_req_q      <= load_req_d;
         load_buf_q      <= load_buf_d;
         load_addr_q     <= load_addr_d;
         comp_req_q      <= comp_req_d;
         comp_buf_q      <= comp_buf_d;
         store_req_q     <= store_req_d;
         store_buf_q     <= store_buf_d;
         store_addr_q    <= store_addr_d;
         perr_q          <= perr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign process_active = (state_q == ST_RUN);
   assign process_done   = (state_q == ST_DONE);
   assign load_req       = load_req_q;
   assign load_buf       = load_buf_q;
   assign load_addr      = load_addr_q;
   assign comp_req       = comp_req_q;
   assign comp_buf       = comp_buf_q;
   assign store_req      = store_req_q;
   assign store_buf      = store_buf_q;
   assign store_addr     = store_addr_q;
   assign protocol_err   = perr_q;

endmodule

// File: tb/tb_gcn_batch_sched.sv
// -----------------------------------------------------------------------------
// tb_gcn_batch_sched
//
// The bench plays the load, compute and store units: it answers each request
// after a chosen latency and records when every request and done happened.
// Expected request cycles are then derived from the scheduling rules:
//   load  i : max(start+1, load_done[i-1]+1, store_done[i-NUM_BUF]+2)
//   comp  i : max(comp_done[i-1]+1, load_done[i]+2)
//   store i : max(store_done[i-1]+1, comp_done[i]+2)
//   done    : store_done[n-1]+2 (start+2 when n is 0)
// Slots are i mod NUM_BUF and addresses base + i*stride (mod 2^32).
// -----------------------------------------------------------------------------
module tb_gcn_batch_sched;

   localparam int NB     = 2;
   localparam int MAXB   = 16;
   localparam int AW     = 32;
   localparam int STRIDE = 512;
   localparam int CW     = $clog2(MAXB + 1);
   localparam int BWD    = $clog2(NB);
   localparam int OV     = 8 + 3 * BWD + 2 * AW;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              process_valid;
   logic [CW-1:0]     process_nbatch;
   logic [AW-1:0]     process_raddr;
   logic [AW-1:0]     process_waddr;
   logic              process_active;
   logic              process_done;
   logic              load_req, comp_req, store_req;
   logic [BWD-1:0]    load_buf, comp_buf, store_buf;
   logic [AW-1:0]     load_addr, store_addr;
   logic              load_done, comp_done, store_done;
   logic              protocol_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit exp_perr = 1'b0;

   gcn_batch_sched #(
      .NUM_BUF     (NB),
      .MAX_BATCHES (MAXB),
      .ADDR_WIDTH  (AW),
      .ADDR_STRIDE (STRIDE)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .process_valid  (process_valid),
      .process_nbatch (process_nbatch),
      .process_raddr  (process_raddr),
      .process_waddr  (process_waddr),
      .process_active (process_active),
      .process_done   (process_done),
      .load_req       (load_req),
      .load_buf       (load_buf),
      .load_addr      (load_addr),
      .load_done      (load_done),
      .comp_req       (comp_req),
      .comp_buf       (comp_buf),
      .comp_done      (comp_done),
      .store_req      (store_req),
      .store_buf      (store_buf),
      .store_addr     (store_addr),
      .store_done     (store_done),
      .protocol_err   (protocol_err)
   );

   always #5 clock = ~clock;

   // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic clear_inputs();
      process_valid  = 1'b0;
      process_nbatch = '0;
      process_raddr  = '0;
      process_waddr  = '0;
      load_done      = 1'b0;
      comp_done      = 1'b0;
      store_done     = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      repeat (2) step();
      reset_n  = 1'b1;
      exp_perr = 1'b0;
      step();
   endtask

   function automatic logic [OV-1:0] out_vec();
      return {process_active, process_done, load_req, comp_req, store_req,
              load_buf, comp_buf, store_buf, load_addr, store_addr,
              protocol_err, 2'b00};
   endfunction

   function automatic int pick_lat(input int l);
      return (l == 0) ? int'($urandom_range(1, 6)) : l;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Runs one command to completion while acting as the three units, then
   // compares every request against the rule-derived expectation.
   // lat_* = 0 picks a random latency per request. align holds a ready
   // comp/store done until the other one is ready too, so they coincide.
   task automatic run_batch(input string tag, input int nb_in,
                            input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                            input int lat_l, input int lat_c, input int lat_s,
                            input bit align, input bit noise, output int coinc);
      int n, s, budget, overlap;
      int lreq[$], creq[$], sreq[$], ld[$], cd[$], sd[$];
      int lbuf[$], cbuf[$], sbuf[$];
      logic [AW-1:0] laddr[$], saddr[$];
      int l_due, c_due, s_due;
      int act_first, act_cnt, done_cyc, done_cnt, exp_done;
      bit fire_l, fire_c, fire_s, finished, detail;

      n = (nb_in > MAXB) ? MAXB : nb_in;
      l_due = -1; c_due = -1; s_due = -1;
      coinc = 0; overlap = 0; act_first = -1; act_cnt = 0;
      done_cyc = -1; done_cnt = 0; finished = 1'b0;

      process_valid  = 1'b1;
      process_nbatch = CW'(nb_in);
      process_raddr  = ra;
      process_waddr  = wa;
      s = cyc;
      step();
      process_valid = 1'b0;

      budget = 3000;
      while (!finished && budget > 0) begin
         if (load_req) begin
            if (l_due != -1) overlap++;
            lreq.push_back(cyc); laddr.push_back(load_addr); lbuf.push_back(int'(load_buf));
            l_due = cyc + pick_lat(lat_l);
         end
         if (comp_req) begin
            if (c_due != -1) overlap++;
            creq.push_back(cyc); cbuf.push_back(int'(comp_buf));
            c_due = cyc + pick_lat(lat_c);
         end
         if (store_req) begin
            if (s_due != -1) overlap++;
            sreq.push_back(cyc); saddr.push_back(store_addr); sbuf.push_back(int'(store_buf));
            s_due = cyc + pick_lat(lat_s);
         end
         if (process_active) begin
            if (act_first < 0) act_first = cyc;
            act_cnt++;
         end
         if (process_done) begin
            done_cnt++;
            done_cyc = cyc;
            finished = 1'b1;
         end

         fire_l = (l_due != -1) && (cyc >= l_due);
         fire_c = (c_due != -1) && (cyc >= c_due) && (!align || s_due == -1 || cyc >= s_due);
         fire_s = (s_due != -1) && (cyc >= s_due) && (!align || c_due == -1 || cyc >= c_due);
         load_done  = fire_l;
         comp_done  = fire_c;
         store_done = fire_s;
         if (fire_l) begin ld.push_back(cyc); l_due = -1; end
         if (fire_c) begin cd.push_back(cyc); c_due = -1; end
         if (fire_s) begin sd.push_back(cyc); s_due = -1; end
         if (fire_c && fire_s) coinc++;

         // Start requests while busy must be ignored.
         if (noise && !finished) begin
            process_valid  = 1'($urandom_range(0, 1));
            process_nbatch = CW'($urandom_range(0, MAXB));
            process_raddr  = $urandom;
            process_waddr  = $urandom;
         end else begin
            process_valid = 1'b0;
         end
         step();
         budget--;
      end
      load_done = 1'b0; comp_done = 1'b0; store_done = 1'b0; process_valid = 1'b0;

      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL %s timeout: process_done not seen within cycle budget", tag);
         do_reset();
         return;
      end

      checks++;
      if (process_active !== 1'b0 || process_done !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_after_done: active=%b done=%b, want 0 0", tag, process_active, process_done);
      end
      checks++;
      if (overlap != 0) begin
         errors++;
         $display("FAIL %s outstanding: %0d requests while one pending, want 0", tag, overlap);
      end
      checks++;
      if (lreq.size() != n || creq.size() != n || sreq.size() != n) begin
         errors++;
         $display("FAIL %s req_count: load=%0d comp=%0d store=%0d, want %0d each",
                  tag, lreq.size(), creq.size(), sreq.size(), n);
      end
      checks++;
      if (protocol_err !== exp_perr) begin
         errors++;
         $display("FAIL %s protocol_err: got %b want %b", tag, protocol_err, exp_perr);
      end

      detail = (lreq.size() == n) && (creq.size() == n) && (sreq.size() == n) &&
               (ld.size() == n) && (cd.size() == n) && (sd.size() == n);
      if (!detail) return;

      for (int i = 0; i < n; i++) begin
         int el, ec, es;
         logic [AW-1:0] ela, esa;
         el = s + 1;
         if (i > 0)   el = imax(el, ld[i-1] + 1);
         if (i >= NB) el = imax(el, sd[i-NB] + 2);
         ec = ld[i] + 2;
         if (i > 0)   ec = imax(ec, cd[i-1] + 1);
         es = cd[i] + 2;
         if (i > 0)   es = imax(es, sd[i-1] + 1);
         ela = ra + AW'(i) * AW'(STRIDE);
         esa = wa + AW'(i) * AW'(STRIDE);

         checks++;
         if (lreq[i] != el || laddr[i] !== ela || lbuf[i] != i % NB) begin
            errors++;
            $display("FAIL %s load[%0d]: cyc=%0d addr=%h buf=%0d, want cyc=%0d addr=%h buf=%0d",
                     tag, i, lreq[i] - s, laddr[i], lbuf[i], el - s, ela, i % NB);
         end
         checks++;
         if (creq[i] != ec || cbuf[i] != i % NB) begin
            errors++;
            $display("FAIL %s comp[%0d]: cyc=%0d buf=%0d, want cyc=%0d buf=%0d",
                     tag, i, creq[i] - s, cbuf[i], ec - s, i % NB);
         end
         checks++;
         if (sreq[i] != es || saddr[i] !== esa || sbuf[i] != i % NB) begin
            errors++;
            $display("FAIL %s store[%0d]: cyc=%0d addr=%h buf=%0d, want cyc=%0d addr=%h buf=%0d",
                     tag, i, sreq[i] - s, saddr[i], sbuf[i], es - s, esa, i % NB);
         end
      end

      exp_done = (n == 0) ? s + 2 : sd[n-1] + 2;
      checks++;
      if (done_cyc != exp_done || done_cnt != 1) begin
         errors++;
         $display("FAIL %s process_done: cyc=%0d pulses=%0d, want cyc=%0d pulses=1",
                  tag, done_cyc - s, done_cnt, exp_done - s);
      end
      checks++;
      if (act_first != s + 1 || act_cnt != exp_done - s - 1) begin
         errors++;
         $display("FAIL %s process_active: first=%0d cycles=%0d, want first=1 cycles=%0d",
                  tag, act_first - s, act_cnt, exp_done - s - 1);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      #12;
      checks++;
      if (out_vec() !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", out_vec());
      end
      step();
      reset_n = 1'b1;
      step();
      step();
      checks++;
      if (out_vec() !== '0) begin
         errors++;
         $display("FAIL idle_outputs: got %h want 0", out_vec());
      end
   endtask

   task automatic test_single();
      int c;
      run_batch("single", 1, 32'h0000_1000, 32'h0000_8000, 3, 3, 3, 1'b0, 1'b0, c);
   endtask

   task automatic test_full();
      int c;
      run_batch("full", 4, 32'h0000_1000, 32'h0000_8000, 1, 10, 2, 1'b0, 1'b0, c);
   endtask

   task automatic test_zero();
      int c;
      run_batch("zero", 0, 32'h0000_1000, 32'h0000_8000, 1, 1, 1, 1'b0, 1'b0, c);
   endtask

   task automatic test_simultaneous();
      int c;
      run_batch("simul", 6, 32'h0001_0000, 32'h0002_0000, 1, 2, 3, 1'b1, 1'b0, c);
      checks++;
      if (c == 0) begin
         errors++;
         $display("FAIL simul_coincide: %0d comp/store done coincidences, want >0", c);
      end
   endtask

   task automatic test_protocol_err();
      int c;
      store_done = 1'b1;
      step();
      store_done = 1'b0;
      checks++;
      if (protocol_err !== 1'b1 || process_active !== 1'b0) begin
         errors++;
         $display("FAIL perr_set: err=%b active=%b, want 1 0", protocol_err, process_active);
      end
      exp_perr = 1'b1;
      step();
      step();
      checks++;
      if (protocol_err !== 1'b1) begin
         errors++;
         $display("FAIL perr_sticky: got %b want 1", protocol_err);
      end
      run_batch("perr_run", 2, 32'h0000_4000, 32'h0000_6000, 0, 0, 0, 1'b0, 1'b0, c);
   endtask

   task automatic test_reset_mid();
      int seen, budget, l_due, c;
      process_valid  = 1'b1;
      process_nbatch = CW'(4);
      process_raddr  = 32'h0000_2000;
      process_waddr  = 32'h0000_9000;
      step();
      process_valid = 1'b0;
      seen = 0; budget = 200; l_due = -1;
      while (seen < 2 && budget > 0) begin
         load_done = (l_due == cyc);
         if (load_done) l_due = -1;
         if (load_req) begin
            seen++;
            l_due = cyc + 1;
         end
         step();
         budget--;
      end
      load_done = 1'b0;
      checks++;
      if (seen != 2) begin
         errors++;
         $display("FAIL reset_mid_loads: saw %0d load_req, want 2", seen);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (out_vec() !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h want 0", out_vec());
      end
      step();
      reset_n  = 1'b1;
      exp_perr = 1'b0;
      step();
      run_batch("after_reset", 3, 32'h0000_0000, 32'h0000_0040, 0, 0, 0, 1'b0, 1'b0, c);
   endtask

   task automatic test_clamp();
      int c;
      run_batch("clamp", 31, 32'hFFFF_F000, 32'h0000_0100, 0, 0, 0, 1'b0, 1'b1, c);
   endtask

   task automatic test_random();
      int c;
      for (int k = 0; k < 6; k++) begin
         run_batch("random", int'($urandom_range(0, 20)), $urandom, $urandom,
                   0, 0, 0, 1'($urandom_range(0, 1)), 1'b1, c);
      end
   endtask

   initial begin
      clear_inputs();
      reset_n = 1'b0;
      test_reset();
      test_single();
      test_full();
      test_zero();
      test_simultaneous();
      test_protocol_err();
      test_reset_mid();
      test_clamp();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gcn_batch_sched.md
Name: gcn_batch_sched

Overview:
- Multi-batch process scheduler for the GCN backend; replaces the single-batch swap/valid/done flow.
- Accepts one process command of N batches and rotates NUM_BUF global-buffer slots through three phases: load (DRAM->GB), compute (MAC array) and store (GB->DRAM).
- Phases of different batches overlap. Issues in-order per-unit requests with slot index and address.
- Sits between the process control interface and the dram2gb / macarray / gb2dram controllers.

Parameters:
- NUM_BUF, 2, number of global-buffer slots (>=2).
- MAX_BATCHES, 16, maximum batches per process command.
- ADDR_WIDTH, 32, DRAM address width.
- ADDR_STRIDE, 512, address increment per batch (BATCH_SIZE*DATA_WIDTH/8).

Ports:
- clock  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- process_valid  in  1  start request; sampled only in IDLE.
- process_nbatch  in  $clog2(MAX_BATCHES+1)  batch count; latched at start.
- process_raddr  in  ADDR_WIDTH  read base address; latched at start.
- process_waddr  in  ADDR_WIDTH  write base address; latched at start.
- process_active  out  1  high from the cycle after start until process_done.
- process_done  out  1  one-cycle completion pulse.
- load_req / comp_req / store_req  out  1  one-cycle issue pulse per unit.
- load_buf / comp_buf / store_buf  out  $clog2(NUM_BUF)  slot index; valid with req and held until next req.
- load_addr / store_addr  out  ADDR_WIDTH  DRAM batch address; valid with req.
- load_done / comp_done / store_done  in  1  one-cycle completion from the unit.
- protocol_err  out  1  sticky; set on a done pulse with no outstanding request.

Behaviour:
- Reset: all outputs 0, all slots FREE, pointers and counters 0, FSM IDLE.
  - Reset mid-operation aborts immediately and drops any pending req.
  - Only reset clears protocol_err.
- Top FSM states and transitions:
  - IDLE -> RUN when process_valid=1; latches nbatch (clamped to MAX_BATCHES), raddr and waddr.
  - RUN -> DONE when stores_completed==nbatch.
  - DONE -> IDLE unconditionally after 1 cycle.
  - process_active=1 in RUN; process_done=1 only in the DONE cycle.
  - process_valid outside IDLE is ignored.
  - nbatch=0: RUN lasts 1 cycle, no reqs, then DONE.
- Slot states cycle FREE -> LOADING -> LOADED -> COMPUTING -> COMPUTED -> STORING -> FREE.
- Each unit has a pointer (load_ptr, comp_ptr, store_ptr). Each advances modulo NUM_BUF on its done pulse.
- Load issue, in RUN:
  - Condition: load unit not busy, slot[load_ptr]==FREE, loads_issued<nbatch.
  - Registered req next cycle; load_addr = raddr + loads_issued*ADDR_STRIDE, modulo 2^ADDR_WIDTH.
  - Slot -> LOADING; unit busy.
- Compute issue: comp unit not busy and slot[comp_ptr]==LOADED -> comp_req; slot -> COMPUTING.
- Store issue:
  - Condition: store unit not busy and slot[store_ptr]==COMPUTED -> store_req.
  - store_addr = waddr + stores_issued*ADDR_STRIDE; slot -> STORING.
- Done pulses: load_done -> LOADED; comp_done -> COMPUTED; store_done -> FREE and stores_completed++. Each done clears the unit's busy flag.
- Latency:
  - Earliest re-issue on the same unit is the cycle after its done (done at T, new req at T+1).
  - A state change from done at T is visible to other units' issue logic at T+1.
  - First load_req is 1 cycle after the start cycle.
- Simultaneous events: done pulses from different units in the same cycle are all applied; they always target distinct slots.
- Each unit has at most 1 request outstanding.
- Ordering: completion order per unit is in-order; batches complete store in index order.
- Full condition: with all NUM_BUF slots occupied, load stalls until a store_done frees slot[load_ptr].
- A spurious done (unit not busy) sets protocol_err and changes no other state.
- Counter widths: $clog2(MAX_BATCHES+1); address multiply truncated to ADDR_WIDTH.

Test Plan:
- nbatch=1, raddr=0x1000, waddr=0x8000, each unit done 3 cycles after req -> load_req at T+1 (addr 0x1000, buf 0), comp_req, then store_req (addr 0x8000, buf 0); process_done after store_done; process_active low after.
- nbatch=4, NUM_BUF=2, compute slow (10 cycles), loads fast -> third load_req (addr 0x1400, buf 0) held off until the first store_done; buf sequence 0,1,0,1 on all units.
- nbatch=0 -> no reqs; process_active high 1 cycle; process_done 1 cycle later.
- comp_done and store_done in the same cycle on different slots -> both slots update; next load_req issues the following cycle.
- store_done pulsed in IDLE -> protocol_err=1 and stays 1; a subsequent nbatch=2 run still completes normally.
- reset_n low mid-run after 2 loads -> all reqs 0, process_active 0; new run with raddr=0x0 starts at buf 0, addr 0x0.
